// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction
// fetch (IF) and load/store (MEM). The data side has fixed priority.
// Each access runs over a variable-latency req/ack handshake, with a timeout
// so that a missing ack cannot deadlock the pipeline.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_wmask,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, DM_WAIT, IF_WAIT, IF_DROP} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              bus_err_q, bus_err_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic [7:0]        tmo_next;
  logic              tmo_hit;
  logic              grant_ok;

  // Next-state logic: grant in IDLE, complete, drop or abort while waiting.
  // The requester's req is still high during its done pulse, so no grant is
  // made in a done cycle; this prevents the same access from being issued again.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    bus_err_d   = bus_err_q;
    tmo_cnt_d   = tmo_cnt_q;
    tmo_next    = tmo_cnt_q + 8'd1;
    tmo_hit     = (tmo_next == TIMEOUT_C);
    grant_ok    = !if_done_q && !dm_done_q;

    case (state_q)
      IDLE: begin
        if (grant_ok && dm_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wmask_d = dm_wmask;
          tmo_cnt_d   = 8'd0;
          state_d     = DM_WAIT;
        end else if (grant_ok && if_req && !if_flush) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wmask_d = 4'b0000;
          tmo_cnt_d   = 8'd0;
          state_d     = IF_WAIT;
        end
      end

      DM_WAIT: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          dm_rdata_d = mem_rdata;
          dm_done_d  = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_cnt_d = tmo_next;
          if (tmo_hit) begin
            mem_req_d  = 1'b0;
            bus_err_d  = 1'b1;
            dm_rdata_d = '0;
            dm_done_d  = 1'b1;
            state_d    = IDLE;
          end
        end
      end

      IF_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!if_flush) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_next;
          if (tmo_hit) begin
            mem_req_d = 1'b0;
            bus_err_d = 1'b1;
            state_d   = IDLE;
            if (!if_flush) begin
              if_rdata_d = '0;
              if_done_d  = 1'b1;
            end
          end else if (if_flush) begin
            state_d = IF_DROP;
          end
        end
      end

      IF_DROP: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_next;
          if (tmo_hit) begin
            mem_req_d = 1'b0;
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 4'b0000;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
      tmo_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      bus_err_q   <= bus_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;

  // Stalls are combinational so they release in the same cycle as the done pulse.
  assign stall_mem = dm_req && !dm_done_q;
  assign stall_if  = (if_req && !if_done_q) || stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. The bench plays the memory and both pipeline
// requesters. Expected results come from the access rules: the data side wins,
// there are three cycles minimum per access, flushes discard fetches, the
// timeout aborts with zero data, and reset is asynchronous.
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wmask;
  logic        stall_if, stall_mem;
  logic        mem_req, mem_we, mem_ack, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_if_rdata;
  logic        exp_bus_err;

  // 100 MHz style free-running clock
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  // One comparison: count it, and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Move to 1ns after the next rising edge, where registered outputs are settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data-side access with latency lat (wait cycles before ack); optional concurrent fetch
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wmask, input int lat, input logic [31:0] rdata,
                               input logic with_if, input logic [31:0] pc);
    dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_wmask = wmask;
    if (with_if) begin if_req = 1'b1; if_addr = pc; end
    #1;
    checkOutput("dm_req_stall_mem", {31'b0, stall_mem}, 32'd1);
    checkOutput("dm_req_stall_if", {31'b0, stall_if}, 32'd1);
    tick();
    checkOutput("dm_grant_req", {31'b0, mem_req}, 32'd1);
    checkOutput("dm_grant_we", {31'b0, mem_we}, {31'b0, we});
    checkOutput("dm_grant_addr", mem_addr, addr);
    checkOutput("dm_grant_wdata", mem_wdata, wdata);
    checkOutput("dm_grant_wmask", {28'b0, mem_wmask}, {28'b0, wmask});
    for (int i = 0; i < lat; i++) begin
      mem_ack = 1'b0;
      tick();
      checkOutput("dm_wait_req", {31'b0, mem_req}, 32'd1);
      checkOutput("dm_wait_addr", mem_addr, addr);
      checkOutput("dm_wait_done", {31'b0, dm_done}, 32'd0);
      checkOutput("dm_wait_stall_if", {31'b0, stall_if}, 32'd1);
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    tick();
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    checkOutput("dm_done_pulse", {31'b0, dm_done}, 32'd1);
    checkOutput("dm_done_rdata", dm_rdata, rdata);
    checkOutput("dm_done_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("dm_done_if_done", {31'b0, if_done}, 32'd0);
    checkOutput("dm_done_stall_mem", {31'b0, stall_mem}, 32'd0);
    checkOutput("dm_done_stall_if", {31'b0, stall_if}, {31'b0, with_if});
    checkOutput("dm_done_bus_err", {31'b0, bus_err}, {31'b0, exp_bus_err});
    tick();
    dm_req = 1'b0; dm_we = 1'b0;
    #1;
    checkOutput("dm_after_done", {31'b0, dm_done}, 32'd0);
    checkOutput("dm_after_no_regrant", {31'b0, mem_req}, 32'd0);
    checkOutput("dm_after_rdata_held", dm_rdata, rdata);
  endtask

  // Fetch with latency lat; mode 0 normal, 1 flush while in flight, 2 flush in the ack cycle
  task automatic runFetch(input logic [31:0] addr, input int lat, input logic [31:0] rdata,
                          input int mode, input logic [31:0] new_pc);
    if_req = 1'b1; if_addr = addr; if_flush = 1'b0;
    #1;
    checkOutput("if_req_stall_if", {31'b0, stall_if}, 32'd1);
    tick();
    checkOutput("if_grant_req", {31'b0, mem_req}, 32'd1);
    checkOutput("if_grant_we", {31'b0, mem_we}, 32'd0);
    checkOutput("if_grant_wmask", {28'b0, mem_wmask}, 32'd0);
    checkOutput("if_grant_addr", mem_addr, addr);
    for (int i = 0; i < lat; i++) begin
      if (mode == 1 && i == 0) if_flush = 1'b1;
      tick();
      if_flush = 1'b0;
      if (mode == 1) if_addr = new_pc;
      checkOutput("if_wait_req", {31'b0, mem_req}, 32'd1);
      checkOutput("if_wait_addr", mem_addr, addr);
      checkOutput("if_wait_done", {31'b0, if_done}, 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    if (mode == 2) if_flush = 1'b1;
    tick();
    mem_ack = 1'b0; if_flush = 1'b0; mem_rdata = $urandom;
    if (mode == 0) exp_if_rdata = rdata;
    #1;
    checkOutput("if_done_pulse", {31'b0, if_done}, (mode == 0) ? 32'd1 : 32'd0);
    checkOutput("if_rdata", if_rdata, exp_if_rdata);
    checkOutput("if_done_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("if_done_bus_err", {31'b0, bus_err}, {31'b0, exp_bus_err});
    if (mode == 0) begin
      checkOutput("if_done_stall_if", {31'b0, stall_if}, 32'd0);
      tick();
      if_req = 1'b0;
      #1;
      checkOutput("if_after_done", {31'b0, if_done}, 32'd0);
      checkOutput("if_after_no_regrant", {31'b0, mem_req}, 32'd0);
    end else begin
      if_addr = new_pc;
      #1;
      checkOutput("if_stale_stall_if", {31'b0, stall_if}, 32'd1);
    end
  endtask

  // Safety net: the sequence is finite, but never let a broken DUT hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  // Directed steps followed by a randomized mix, then timeout and reset cases
  initial begin
    logic [31:0] a, d, w, pc;
    int          kind, lat;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wmask = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_if_rdata = '0; exp_bus_err = 1'b0;
    #12;
    checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_wmask", {28'b0, mem_wmask}, 32'd0);
    checkOutput("rst_if_done", {31'b0, if_done}, 32'd0);
    checkOutput("rst_dm_done", {31'b0, dm_done}, 32'd0);
    checkOutput("rst_if_rdata", if_rdata, 32'd0);
    checkOutput("rst_dm_rdata", dm_rdata, 32'd0);
    checkOutput("rst_bus_err", {31'b0, bus_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] load with ack latency 2");
    applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 2, 32'hCAFE0001, 1'b0, 32'h0);

    $display("[TB] simultaneous store and fetch");
    applyStimulus(1'b1, 32'h200, 32'hDEADBEEF, 4'hF, 1, 32'h0BAD0BAD, 1'b1, 32'h40);
    runFetch(32'h40, 1, 32'h00000013, 0, 32'h0);

    $display("[TB] flush while fetch in flight, then refetch");
    runFetch(32'h40, 2, 32'h11111111, 1, 32'h80);
    runFetch(32'h80, 0, 32'h22222222, 0, 32'h0);

    $display("[TB] flush in the ack cycle");
    runFetch(32'h84, 1, 32'h33333333, 2, 32'h90);
    runFetch(32'h90, 0, 32'h44444444, 0, 32'h0);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 4);
      lat  = $urandom_range(0, TMO - 1);
      a    = $urandom & 32'hFFFF_FFFC;
      d    = $urandom;
      w    = $urandom;
      pc   = $urandom & 32'h0000_FFFC;
      case (kind)
        0: applyStimulus(1'b0, a, w, 4'($urandom), lat, d, 1'b0, 32'h0);
        1: applyStimulus(1'b1, a, w, 4'($urandom), lat, d, 1'b0, 32'h0);
        2: runFetch(pc, lat, d, 0, 32'h0);
        3: begin
          applyStimulus(1'b1, a, w, 4'($urandom), lat, $urandom, 1'b1, pc);
          runFetch(pc, $urandom_range(0, TMO - 1), d, 0, 32'h0);
        end
        default: begin
          runFetch(pc, (lat == 0) ? 1 : lat, $urandom, 1, pc + 32'h100);
          runFetch(pc + 32'h100, lat, d, 0, 32'h0);
        end
      endcase
    end

    $display("[TB] timeout with ack held low");
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_wdata = 32'h0; dm_wmask = 4'h0;
    #1;
    tick();
    checkOutput("tmo_grant_req", {31'b0, mem_req}, 32'd1);
    for (int i = 1; i < TMO; i++) begin
      tick();
      checkOutput("tmo_wait_req", {31'b0, mem_req}, 32'd1);
      checkOutput("tmo_wait_bus_err", {31'b0, bus_err}, 32'd0);
    end
    tick();
    exp_bus_err = 1'b1;
    checkOutput("tmo_abort_req", {31'b0, mem_req}, 32'd0);
    checkOutput("tmo_abort_bus_err", {31'b0, bus_err}, 32'd1);
    checkOutput("tmo_abort_done", {31'b0, dm_done}, 32'd1);
    checkOutput("tmo_abort_rdata", dm_rdata, 32'd0);
    tick();
    dm_req = 1'b0;
    #1;
    checkOutput("tmo_sticky", {31'b0, bus_err}, 32'd1);
    checkOutput("tmo_done_once", {31'b0, dm_done}, 32'd0);
    applyStimulus(1'b0, 32'h304, 32'h0, 4'h0, 1, 32'h55AA55AA, 1'b0, 32'h0);

    $display("[TB] asynchronous reset during data access");
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    #1;
    tick();
    tick();
    checkOutput("rstmid_before_req", {31'b0, mem_req}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    exp_bus_err = 1'b0; exp_if_rdata = '0;
    checkOutput("rstmid_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rstmid_bus_err", {31'b0, bus_err}, 32'd0);
    checkOutput("rstmid_dm_rdata", dm_rdata, 32'd0);
    dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    tick();
    mem_ack = 1'b0;
    checkOutput("late_ack_dm_done", {31'b0, dm_done}, 32'd0);
    checkOutput("late_ack_if_done", {31'b0, if_done}, 32'd0);
    checkOutput("late_ack_mem_req", {31'b0, mem_req}, 32'd0);
    tick();
    checkOutput("late_ack_dm_done2", {31'b0, dm_done}, 32'd0);
    runFetch(32'hC0, 0, 32'h66666666, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences each access over a variable-latency req/ack memory handshake.
- Returns data to the winning requester.
- Drives stall requests that the hazard unit ORs into PC/IF-ID enables and EX-MEM/MEM-WB enables.
- Discards instruction fetches that a branch/jump flush makes stale.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF stage requests a fetch.
- if_addr  in  ADDR_W  fetch address (PC).
- if_flush  in  1  control-hazard flush; the current or in-flight fetch is stale.
- if_done  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  fetched instruction.
- dm_req  in  1  MEM stage requests a load or store.
- dm_we  in  1  1 = store.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_wmask  in  4  byte enables for the store.
- dm_done  out  1  one-cycle pulse; access complete; dm_rdata is valid for loads.
- dm_rdata  out  DATA_W  load data.
- stall_if  out  1  freeze PC and IF/ID.
- stall_mem  out  1  freeze the whole pipeline up to MEM.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  4  memory byte enables.
- mem_ack  in  1  memory completes the access; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async assert, synchronous release):
  - state = IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_wmask = 0.
  - if_done, dm_done = 0; if_rdata, dm_rdata = 0.
  - bus_err = 0; timeout counter = 0.
- States: IDLE, DM_WAIT, IF_WAIT, IF_DROP.
- IDLE:
  - If dm_req: latch the dm_* request into the mem_* registers, set mem_req=1, go to DM_WAIT. Data side has fixed priority because it is the older instruction.
  - Else if if_req && !if_flush: latch if_addr, set mem_we=0 and mem_wmask=0, set mem_req=1, go to IF_WAIT.
  - Else stay in IDLE.
  - mem_ack is ignored in IDLE.
- Outstanding request: all mem_* outputs are registered and held stable in DM_WAIT/IF_WAIT/IF_DROP until the cycle mem_ack=1.
- DM_WAIT on mem_ack:
  - Next edge: mem_req=0, dm_rdata=mem_rdata (loads and stores alike), dm_done=1 for one cycle, go to IDLE.
- IF_WAIT on mem_ack:
  - Next edge: mem_req=0, if_rdata=mem_rdata, if_done=1 for one cycle, go to IDLE.
  - If if_flush=1 in the ack cycle, the data is stale: no if_done, if_rdata unchanged.
- IF_WAIT with if_flush=1 and no ack: go to IF_DROP.
  - The request cannot be withdrawn from memory, so mem_req stays asserted.
- IF_DROP on mem_ack: go to IDLE with no if_done. The refetch at the new PC starts from IDLE.
- Minimum access: 3 cycles from request to done pulse (grant edge, ack cycle, done edge). A new grant is possible on the cycle after the done pulse.
- Stalls (combinational):
  - stall_mem = dm_req && !dm_done.
  - stall_if = (if_req && !if_done) || stall_mem.
- Timeout:
  - Counter clears on each grant and increments every WAIT/DROP cycle without ack.
  - When the counter reaches TIMEOUT: set bus_err=1 (sticky until reset), drop mem_req, go to IDLE.
  - The pending side gets its done pulse with rdata=0 (IF_DROP: none), so the pipeline cannot deadlock.
- Reset mid-access: everything returns to IDLE immediately. A late mem_ack after reset is ignored.
- if_req/dm_req are levels from the pipeline and are held until the matching done pulse. A requester drops its req in the cycle after done unless it issues the next access.

Test Plan:
- Load, memory ack latency 2: dm_req=1, dm_we=0, addr=0x100, ack 2 cycles after mem_req → mem_addr=0x100, mem_we=0; dm_done 1 cycle after ack with dm_rdata=ack data; stall_mem high until done.
- Simultaneous requests: if_req (pc 0x40) and dm_req (store 0x200, wdata 0xDEADBEEF, wmask 0xF) in the same cycle → store issued first; fetch of 0x40 issued after dm_done; stall_if high throughout.
- Flush in flight: fetch 0x40 outstanding, if_flush pulsed before ack → IF_DROP; no if_done on ack; next fetch of 0x80 issued from IDLE and returns correctly.
- Flush in the ack cycle: if_flush=1 together with mem_ack → no if_done, if_rdata unchanged.
- Timeout with TIMEOUT=4 and mem_ack held 0: load request → mem_req drops after 4 wait cycles; bus_err=1 stays set; dm_done pulses with dm_rdata=0.
- Async reset asserted while in DM_WAIT → mem_req=0 and state IDLE immediately; a later mem_ack produces no done pulse.
